ctrl_sequencer: RTL and testbench
=================================

// Module: ctrl_sequencer
// PURPOSE
//  Multi-cycle control unit for the 8-bit processor; sits directly upstream of the alu.
//  Fetches instruction bytes, decodes them, drives alu_op and register-file selects,
//  and commits the registered alu result and flags. Also handles immediates, jumps and halt.
// PARAMETERS
//  N       8   datapath / PC / instruction width
//  RSEL    2   register-select width (4 GPRs)
// PORTS
//  clk          in   1     single clock, rising edge
//  rst          in   1     synchronous, active-high reset
//  instr_addr   out  N     fetch address (PC)
//  instr_req    out  1     fetch request; held until instr_valid
//  instr_valid  in   1     instr_data valid this cycle; may be high in the same cycle as req
//  instr_data   in   N     fetched byte
//  alu_op       out  4     ALU opcode (shared ALU_* defines)
//  rf_sel_a     out  RSEL  operand A register (rd)
//  rf_sel_b     out  RSEL  operand B register (rs)
//  rf_wr_en     out  1     register-file write strobe
//  rf_wr_sel    out  RSEL  write destination (rd)
//  wr_src_imm   out  1     1: write imm_out; 0: write alu_out
//  imm_out      out  N     latched immediate byte
//  carry_out    in   1     from alu (registered there)
//  zero_flag    in   1     from alu (registered there)
//  flag_c       out  1     architectural carry flag
//  flag_z       out  1     architectural zero flag
//  halted       out  1     core stopped
//  illegal_op   out  1     one-cycle pulse on undefined opcode
// BEHAVIOUR
//  Instruction byte: [7:4] opcode, [3:2] rd, [1:0] rs.
//  Opcode map:
//   0 NOP; 1 ADD; 2 SUB; 3 INC; 4 DEC; 5 AND; 6 XOR; 7 OR (ALU ops, result -> rd).
//   8 LDI rd,#imm; 9 JMP #imm; A JZ #imm; B JC #imm (each uses a 2nd byte).
//   F HLT. C,D,E are illegal.
//  Reset (synchronous): state=FETCH, PC=0, flag_c=flag_z=0, imm_out=0.
//   All strobes are 0 during and after reset, with alu_op=ALU_NOP.
//   instr_req rises in the first cycle after rst falls.
//  FSM states:
//   FETCH: instr_req=1 with addr=PC.
//    On instr_valid, latch IR and PC<=PC+1 (mod 2^N, FF->00); go to DECODE.
//   DECODE (1 cycle):
//    ALU op -> EXECUTE; 8..B -> FETCH_IMM; F -> HALT.
//    0 -> FETCH. Illegal -> pulse illegal_op, then FETCH.
//   FETCH_IMM: request at PC; on valid, latch imm_out and PC<=PC+1. Then:
//    LDI -> WRITEBACK.
//    JMP -> PC<=imm, FETCH.
//    JZ/JC -> PC<=imm only if flag_z/flag_c=1; else keep PC+1. Then FETCH.
//   EXECUTE: alu_op=decoded op, rf_sel_a=rd, rf_sel_b=rs, for exactly one cycle.
//   WRITEBACK:
//    rf_wr_en=1 and rf_wr_sel=rd for one cycle; wr_src_imm=1 for LDI only.
//    For ALU ops, flag_c<=carry_out and flag_z<=zero_flag.
//    LDI leaves the flags unchanged. Then FETCH.
//   HALT: halted=1, no requests; held until rst.
//  alu_op=ALU_NOP in every state except EXECUTE.
//  Latency: ALU op = 4 cycles with zero-wait fetch; LDI = 4; jumps = 3 (+ fetch waits).
//  While waiting on instr_valid: instr_addr is stable and no other output toggles.
//  Reset has priority at all times. Reset mid-EXECUTE aborts the instruction:
//   no rf_wr_en and no flag update.
// STRUCTURE
//  Shared definitions file:
//   ALU_* op codes (4-bit); the OP_* opcode map; FSM state encodings.
//  Sub-module ctrl_decode: combinational.
//   Maps IR to {alu_op, is_alu, is_imm, is_jump, cond, is_halt, illegal}.
//  Top level holds the FSM, PC, IR, imm and flag registers.
// TESTING
//  1 Reset: rst=1 for 2 clks -> instr_req=0, alu_op=NOP, halted=0.
//    Cycle after release -> instr_req=1, instr_addr=00.
//  2 Fetch 0x16 (ADD R1,R2), zero-wait:
//    -> DECODE; then EXECUTE with alu_op=ALU_ADD, rf_sel_a=1, rf_sel_b=2.
//    -> Next cycle rf_wr_en=1, rf_wr_sel=1, wr_src_imm=0, PC=01.
//    -> Next instr_req is 4 cycles after the first.
//  3 LDI: bytes 0x8C, 0x80 -> rf_wr_en=1, rf_wr_sel=3, wr_src_imm=1, imm_out=80.
//    -> PC=02 and flags unchanged.
//  4 Flags and JZ: DEC with zero_flag=1 -> flag_z=1.
//    -> JZ 0x40 fetches next from 40.
//    -> Repeat with zero_flag=0: next fetch from PC+2.
//  5 Fetch waits and wrap:
//    instr_valid delayed 3 clks -> instr_req held, addr stable, no strobes.
//    Fetch at PC=FF -> next addr 00.
//  6 HLT, illegal, reset abort:
//    0xF0 -> halted=1, instr_req=0 for 20 clks.
//    0xC0 -> illegal_op high for exactly 1 clk, then fetch resumes.
//    rst pulsed during EXECUTE -> rf_wr_en never asserts.

Source files
------------

// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the 8-bit processor control unit: ALU op codes,
// instruction opcode map, FSM states and the decoded-instruction record.
package ctrl_sequencer_pkg;

  localparam logic [3:0] ALU_NOP = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_INC = 4'h3;
  localparam logic [3:0] ALU_DEC = 4'h4;
  localparam logic [3:0] ALU_AND = 4'h5;
  localparam logic [3:0] ALU_XOR = 4'h6;
  localparam logic [3:0] ALU_OR  = 4'h7;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_INC = 4'h3;
  localparam logic [3:0] OP_DEC = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_FETCH_IMM = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'd0,
    COND_Z      = 2'd1,
    COND_C      = 2'd2
  } cond_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       is_alu;
    logic       is_imm;
    logic       is_jump;
    cond_e      cond;
    logic       is_halt;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/ctrl_sequencer_decode.sv
// Combinational instruction decoder: opcode nibble -> control record.
module ctrl_decode
  import ctrl_sequencer_pkg::*;
(
  input  logic [3:0] opcode_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o        = '0;
    dec_o.alu_op = ALU_NOP;
    dec_o.cond   = COND_ALWAYS;
    unique case (opcode_i)
      OP_NOP: ;
      OP_ADD: begin dec_o.is_alu = 1'b1; dec_o.alu_op = ALU_ADD; end
      OP_SUB: begin dec_o.is_alu = 1'b1; dec_o.alu_op = ALU_SUB; end
      OP_INC: begin dec_o.is_alu = 1'b1; dec_o.alu_op = ALU_INC; end
      OP_DEC: begin dec_o.is_alu = 1'b1; dec_o.alu_op = ALU_DEC; end
      OP_AND: begin dec_o.is_alu = 1'b1; dec_o.alu_op = ALU_AND; end
      OP_XOR: begin dec_o.is_alu = 1'b1; dec_o.alu_op = ALU_XOR; end
      OP_OR:  begin dec_o.is_alu = 1'b1; dec_o.alu_op = ALU_OR;  end
      OP_LDI: dec_o.is_imm = 1'b1;
      OP_JMP: begin dec_o.is_imm = 1'b1; dec_o.is_jump = 1'b1; end
      OP_JZ:  begin dec_o.is_imm = 1'b1; dec_o.is_jump = 1'b1; dec_o.cond = COND_Z; end
      OP_JC:  begin dec_o.is_imm = 1'b1; dec_o.is_jump = 1'b1; dec_o.cond = COND_C; end
      OP_HLT: dec_o.is_halt = 1'b1;
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control FSM for the 8-bit core: fetch, decode, execute on the
// external ALU, write back, immediates, conditional jumps and halt.
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int N    = 8,
  parameter int RSEL = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [N-1:0]    instr_addr,
  output logic            instr_req,
  input  logic            instr_valid,
  input  logic [N-1:0]    instr_data,
  output logic [3:0]      alu_op,
  output logic [RSEL-1:0] rf_sel_a,
  output logic [RSEL-1:0] rf_sel_b,
  output logic            rf_wr_en,
  output logic [RSEL-1:0] rf_wr_sel,
  output logic            wr_src_imm,
  output logic [N-1:0]    imm_out,
  input  logic            carry_out,
  input  logic            zero_flag,
  output logic            flag_c,
  output logic            flag_z,
  output logic            halted,
  output logic            illegal_op
);

  state_e         state_q, state_d;
  logic [N-1:0]   pc_q, pc_d;
  logic [N-1:0]   ir_q, ir_d;
  logic [N-1:0]   imm_q, imm_d;
  logic           flag_c_q, flag_c_d;
  logic           flag_z_q, flag_z_d;
  dec_t           dec;
  logic           jump_taken;
  logic [RSEL-1:0] rd, rs;

  assign rd = ir_q[2*RSEL-1:RSEL];
  assign rs = ir_q[RSEL-1:0];

  ctrl_decode u_decode (
    .opcode_i (ir_q[N-1 -: 4]),
    .dec_o    (dec)
  );

  always_comb begin
    unique case (dec.cond)
      COND_Z:  jump_taken = flag_z_q;
      COND_C:  jump_taken = flag_c_q;
      default: jump_taken = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      imm_q    <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  // IR is only consumed in states reached after it has been loaded.
  always_ff @(posedge clk) begin
    ir_q <= ir_d;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    imm_d    = imm_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    unique case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_data;
          pc_d    = pc_q + N'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec.is_alu)       state_d = ST_EXECUTE;
        else if (dec.is_imm)  state_d = ST_FETCH_IMM;
        else if (dec.is_halt) state_d = ST_HALT;
        else                  state_d = ST_FETCH;
      end
      ST_FETCH_IMM: begin
        if (instr_valid) begin
          imm_d = instr_data;
          pc_d  = pc_q + N'(1);
          if (dec.is_jump) begin
            if (jump_taken) pc_d = instr_data;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end
      end
      ST_EXECUTE: state_d = ST_WRITEBACK;
      ST_WRITEBACK: begin
        // The ALU registers its flags, so they are valid during writeback.
        if (dec.is_alu) begin
          flag_c_d = carry_out;
          flag_z_d = zero_flag;
        end
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset masks every strobe combinationally so nothing fires while rst is high.
  always_comb begin
    instr_req  = 1'b0;
    alu_op     = ALU_NOP;
    rf_sel_a   = '0;
    rf_sel_b   = '0;
    rf_wr_en   = 1'b0;
    rf_wr_sel  = '0;
    wr_src_imm = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_FETCH, ST_FETCH_IMM: instr_req = 1'b1;
        ST_DECODE: illegal_op = dec.illegal;
        ST_EXECUTE: begin
          alu_op   = dec.alu_op;
          rf_sel_a = rd;
          rf_sel_b = rs;
        end
        ST_WRITEBACK: begin
          rf_wr_en   = 1'b1;
          rf_wr_sel  = rd;
          wr_src_imm = dec.is_imm & ~dec.is_jump;
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign instr_addr = pc_q;
  assign imm_out    = imm_q;
  assign flag_c     = flag_c_q;
  assign flag_z     = flag_z_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed cycle table, hand-written corner sequences,
// then a random program checked against an instruction-level reference model.
module tb_ctrl_sequencer;
  import ctrl_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr_addr;
  logic       instr_req;
  logic       instr_valid;
  logic [7:0] instr_data;
  logic [3:0] alu_op;
  logic [1:0] rf_sel_a, rf_sel_b, rf_wr_sel;
  logic       rf_wr_en, wr_src_imm;
  logic [7:0] imm_out;
  logic       carry_out, zero_flag;
  logic       flag_c, flag_z, halted, illegal_op;

  always #5 clk = ~clk;

  ctrl_sequencer #(.N(8), .RSEL(2)) dut (
    .clk(clk), .rst(rst),
    .instr_addr(instr_addr), .instr_req(instr_req),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .alu_op(alu_op), .rf_sel_a(rf_sel_a), .rf_sel_b(rf_sel_b),
    .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel), .wr_src_imm(wr_src_imm),
    .imm_out(imm_out), .carry_out(carry_out), .zero_flag(zero_flag),
    .flag_c(flag_c), .flag_z(flag_z), .halted(halted), .illegal_op(illegal_op)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rst, vld;
    logic [7:0] data;
    logic       cy, zf;
    logic       req;
    logic [7:0] addr;
    logic [3:0] op;
    logic [1:0] sa, sb;
    logic       wen;
    logic [1:0] wsel;
    logic       simm;
    logic [7:0] imm;
    logic       fc, fz, halt, ill;
  } vec_t;

  typedef struct packed { logic [7:0] addr; logic fc, fz; } fetch_t;
  typedef struct packed { logic [3:0] op; logic [1:0] rd, rs; } alu_t;
  typedef struct packed { logic [1:0] rd; logic simm; logic [7:0] imm; } wr_t;

  logic [7:0] mem [256];
  fetch_t     exp_fetch[$];
  alu_t       exp_alu[$];
  wr_t        exp_wr[$];
  logic [1:0] alu_resp[$];
  int         req_fetch, req_alu, req_wr, req_ill;
  int         n_fetch, n_alu, n_wr, n_ill;
  int         wait_cnt, max_wait;
  bit         auto_en, mon_en;
  vec_t       tbl[31];
  vec_t       got;
  int         bad, cyc;
  bit         found;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic r, vl, input logic [7:0] d, input logic c, z,
                             input logic rq, input logic [7:0] a, input logic [3:0] o,
                             input logic [1:0] sa, sb, input logic we, input logic [1:0] ws,
                             input logic si, input logic [7:0] im, input logic fc, fz, h, il);
    return '{r, vl, d, c, z, rq, a, o, sa, sb, we, ws, si, im, fc, fz, h, il};
  endfunction

  function automatic logic [3:0] alu_code(input logic [3:0] opc);
    case (opc)
      4'h1: return ALU_ADD;
      4'h2: return ALU_SUB;
      4'h3: return ALU_INC;
      4'h4: return ALU_DEC;
      4'h5: return ALU_AND;
      4'h6: return ALU_XOR;
      default: return ALU_OR;
    endcase
  endfunction

  // Instruction-level walk of the program in mem, producing the expected event streams.
  task automatic build_model(input int k_req, input int k_tot);
    logic [7:0] pc, b, imm;
    logic       fc, fz, c, z;
    logic [3:0] opc;
    int         ill;
    pc = 8'h00; fc = 1'b0; fz = 1'b0; ill = 0;
    for (int k = 0; k < k_tot; k++) begin
      b = mem[pc]; opc = b[7:4];
      exp_fetch.push_back({pc, fc, fz});
      pc = pc + 8'd1;
      if (opc >= 4'h1 && opc <= 4'h7) begin
        c = 1'($urandom); z = 1'($urandom);
        alu_resp.push_back({c, z});
        exp_alu.push_back({alu_code(opc), b[3:2], b[1:0]});
        exp_wr.push_back({b[3:2], 1'b0, 8'h00});
        fc = c; fz = z;
      end else if (opc >= 4'h8 && opc <= 4'hB) begin
        imm = mem[pc];
        exp_fetch.push_back({pc, fc, fz});
        pc = pc + 8'd1;
        if (opc == 4'h8) exp_wr.push_back({b[3:2], 1'b1, imm});
        else if (opc == 4'h9 || (opc == 4'hA && fz) || (opc == 4'hB && fc)) pc = imm;
      end else if (opc >= 4'hC && opc <= 4'hE) begin
        ill++;
      end
      if (k == k_req - 1) begin
        req_fetch = exp_fetch.size(); req_alu = exp_alu.size();
        req_wr = exp_wr.size(); req_ill = ill;
      end
    end
  endtask

  task automatic monitor();
    fetch_t f; alu_t a; wr_t w;
    if (instr_req && instr_valid) begin
      check("fetch_q", 32'(exp_fetch.size() > 0), 32'd1);
      if (exp_fetch.size() > 0) begin
        f = exp_fetch.pop_front();
        check("fetch", 32'({instr_addr, flag_c, flag_z}), 32'(f));
        n_fetch++;
      end
    end
    if (alu_op != ALU_NOP) begin
      check("alu_q", 32'(exp_alu.size() > 0), 32'd1);
      if (exp_alu.size() > 0) begin
        a = exp_alu.pop_front();
        check("alu", 32'({alu_op, rf_sel_a, rf_sel_b}), 32'(a));
        n_alu++;
      end
    end
    if (rf_wr_en) begin
      check("wr_q", 32'(exp_wr.size() > 0), 32'd1);
      if (exp_wr.size() > 0) begin
        w = exp_wr.pop_front();
        check("wr", 32'({rf_wr_sel, wr_src_imm, wr_src_imm ? imm_out : 8'h00}), 32'(w));
        n_wr++;
      end
    end
    if (illegal_op) n_ill++;
  endtask

  // Memory responder with random wait states, plus a stub for the registered ALU.
  task automatic drive();
    if (instr_req && wait_cnt == 0) begin
      instr_valid = 1'b1;
      instr_data  = mem[instr_addr];
      wait_cnt    = $urandom_range(0, max_wait);
    end else begin
      instr_valid = 1'b0;
      instr_data  = 8'($urandom);
      if (instr_req) wait_cnt--;
    end
    if (alu_op != ALU_NOP && alu_resp.size() > 0) {carry_out, zero_flag} = alu_resp.pop_front();
  endtask

  task automatic tick();
    @(negedge clk);
    if (mon_en) monitor();
    @(posedge clk);
    #1;
    if (auto_en) drive();
  endtask

  task automatic do_reset();
    rst = 1'b1; wait_cnt = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_data = 8'h00;
    carry_out = 1'b0; zero_flag = 1'b0;
    auto_en = 1'b0; mon_en = 1'b0; wait_cnt = 0; max_wait = 0;
    n_fetch = 0; n_alu = 0; n_wr = 0; n_ill = 0;

    //          rst vld data  cy zf | req addr  op       sa sb we ws si imm   fc fz h il
    tbl[0]  = v(1, 0, 8'h00, 0, 0,   0, 8'h00, ALU_NOP, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    tbl[1]  = v(0, 1, 8'h16, 0, 0,   1, 8'h00, ALU_NOP, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    tbl[2]  = v(0, 0, 8'h00, 0, 0,   0, 8'h01, ALU_NOP, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    tbl[3]  = v(0, 0, 8'h00, 1, 0,   0, 8'h01, ALU_ADD, 1, 2, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    tbl[4]  = v(0, 0, 8'h00, 1, 0,   0, 8'h01, ALU_NOP, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    tbl[5]  = v(0, 1, 8'h8C, 1, 0,   1, 8'h01, ALU_NOP, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
    tbl[6]  = v(0, 0, 8'h00, 1, 0,   0, 8'h02, ALU_NOP, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
    tbl[7]  = v(0, 1, 8'h80, 1, 0,   1, 8'h02, ALU_NOP, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
    tbl[8]  = v(0, 0, 8'h00, 0, 1,   0, 8'h03, ALU_NOP, 0, 0, 1, 3, 1, 8'h80, 1, 0, 0, 0);
    tbl[9]  = v(0, 1, 8'h40, 0, 1,   1, 8'h03, ALU_NOP, 0, 0, 0, 0, 0, 8'h80, 1, 0, 0, 0);
    tbl[10] = v(0, 0, 8'h00, 0, 1,   0, 8'h04, ALU_NOP, 0, 0, 0, 0, 0, 8'h80, 1, 0, 0, 0);
    tbl[11] = v(0, 0, 8'h00, 0, 1,   0, 8'h04, ALU_DEC, 0, 0, 0, 0, 0, 8'h80, 1, 0, 0, 0);
    tbl[12] = v(0, 0, 8'h00, 0, 1,   0, 8'h04, ALU_NOP, 0, 0, 1, 0, 0, 8'h80, 1, 0, 0, 0);
    tbl[13] = v(0, 1, 8'hA0, 0, 1,   1, 8'h04, ALU_NOP, 0, 0, 0, 0, 0, 8'h80, 0, 1, 0, 0);
    tbl[14] = v(0, 0, 8'h00, 0, 1,   0, 8'h05, ALU_NOP, 0, 0, 0, 0, 0, 8'h80, 0, 1, 0, 0);
    tbl[15] = v(0, 1, 8'h40, 0, 1,   1, 8'h05, ALU_NOP, 0, 0, 0, 0, 0, 8'h80, 0, 1, 0, 0);
    tbl[16] = v(0, 0, 8'h33, 0, 1,   1, 8'h40, ALU_NOP, 0, 0, 0, 0, 0, 8'h40, 0, 1, 0, 0);
    tbl[17] = v(0, 0, 8'h55, 0, 1,   1, 8'h40, ALU_NOP, 0, 0, 0, 0, 0, 8'h40, 0, 1, 0, 0);
    tbl[18] = v(0, 0, 8'h77, 0, 1,   1, 8'h40, ALU_NOP, 0, 0, 0, 0, 0, 8'h40, 0, 1, 0, 0);
    tbl[19] = v(0, 1, 8'h00, 0, 1,   1, 8'h40, ALU_NOP, 0, 0, 0, 0, 0, 8'h40, 0, 1, 0, 0);
    tbl[20] = v(0, 0, 8'h00, 0, 1,   0, 8'h41, ALU_NOP, 0, 0, 0, 0, 0, 8'h40, 0, 1, 0, 0);
    tbl[21] = v(0, 1, 8'h44, 0, 1,   1, 8'h41, ALU_NOP, 0, 0, 0, 0, 0, 8'h40, 0, 1, 0, 0);
    tbl[22] = v(0, 0, 8'h00, 0, 0,   0, 8'h42, ALU_NOP, 0, 0, 0, 0, 0, 8'h40, 0, 1, 0, 0);
    tbl[23] = v(0, 0, 8'h00, 0, 0,   0, 8'h42, ALU_DEC, 1, 0, 0, 0, 0, 8'h40, 0, 1, 0, 0);
    tbl[24] = v(0, 0, 8'h00, 0, 0,   0, 8'h42, ALU_NOP, 0, 0, 1, 1, 0, 8'h40, 0, 1, 0, 0);
    tbl[25] = v(0, 1, 8'hA0, 0, 0,   1, 8'h42, ALU_NOP, 0, 0, 0, 0, 0, 8'h40, 0, 0, 0, 0);
    tbl[26] = v(0, 0, 8'h00, 0, 0,   0, 8'h43, ALU_NOP, 0, 0, 0, 0, 0, 8'h40, 0, 0, 0, 0);
    tbl[27] = v(0, 1, 8'h40, 0, 0,   1, 8'h43, ALU_NOP, 0, 0, 0, 0, 0, 8'h40, 0, 0, 0, 0);
    tbl[28] = v(0, 1, 8'hC0, 0, 0,   1, 8'h44, ALU_NOP, 0, 0, 0, 0, 0, 8'h40, 0, 0, 0, 0);
    tbl[29] = v(0, 0, 8'h00, 0, 0,   0, 8'h45, ALU_NOP, 0, 0, 0, 0, 0, 8'h40, 0, 0, 0, 1);
    tbl[30] = v(0, 0, 8'h00, 0, 0,   1, 8'h45, ALU_NOP, 0, 0, 0, 0, 0, 8'h40, 0, 0, 0, 0);

    @(posedge clk); #1;
    for (int i = 0; i < 31; i++) begin
      rst = tbl[i].rst; instr_valid = tbl[i].vld; instr_data = tbl[i].data;
      carry_out = tbl[i].cy; zero_flag = tbl[i].zf;
      @(negedge clk);
      got = tbl[i];
      got.req = instr_req; got.addr = instr_addr; got.op = alu_op;
      got.sa = rf_sel_a; got.sb = rf_sel_b; got.wen = rf_wr_en; got.wsel = rf_wr_sel;
      got.simm = wr_src_imm; got.imm = imm_out; got.fc = flag_c; got.fz = flag_z;
      got.halt = halted; got.ill = illegal_op;
      checks++;
      if (got !== tbl[i]) begin
        errors++;
        $display("FAIL vec[%0d]: got %h expected %h", i, got, tbl[i]);
      end
      @(posedge clk); #1;
    end

    auto_en = 1'b1; max_wait = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h90; mem[1] = 8'hFF;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (instr_req && instr_addr == 8'hFF) begin found = 1'b1; break; end
      tick();
    end
    check("wrap_reach", 32'(found), 32'd1);
    found = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (instr_req) begin found = 1'b1; break; end
    end
    check("wrap_req", 32'(found), 32'd1);
    check("wrap_addr", 32'(instr_addr), 32'h00);

    mem[0] = 8'hF0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      if (halted) break;
      tick();
    end
    check("halt_set", 32'(halted), 32'd1);
    bad = 0;
    repeat (20) begin
      tick();
      if (instr_req || !halted) bad++;
    end
    check("halt_hold", 32'(bad), 32'd0);

    mem[0] = 8'h16;
    do_reset();
    carry_out = 1'b1; zero_flag = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (alu_op == ALU_ADD) break;
      tick();
    end
    check("abort_exec", 32'(alu_op), 32'(ALU_ADD));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bad = 0;
    repeat (4) begin
      if (rf_wr_en || flag_c || flag_z) bad++;
      tick();
    end
    check("abort_nowb", 32'(bad), 32'd0);

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 239));
    alu_resp.delete();
    build_model(400, 404);
    max_wait = 2;
    do_reset();
    mon_en = 1'b1;
    cyc = 0;
    while (n_fetch < req_fetch && cyc < 20000) begin
      tick();
      cyc++;
    end
    check("rand_progress", 32'(n_fetch >= req_fetch), 32'd1);
    repeat (6) tick();
    mon_en = 1'b0;
    check("rand_alu_cnt", 32'(n_alu >= req_alu), 32'd1);
    check("rand_wr_cnt", 32'(n_wr >= req_wr), 32'd1);
    check("rand_ill_cnt", 32'(n_ill >= req_ill), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
